// File: rtl/ldtu_hamm_ofifo_reader.sv
// Output-FIFO reader for the LiTe-DTU Hamming store: pops 38-bit words,
// corrects single errors and buffers 32-bit data towards the serializer.
module ldtu_hamm_ofifo_reader #(
  parameter int Nbits_ham  = 38,
  parameter int Nbits_data = 32,
  parameter int OBUF_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [Nbits_ham-1:0]  fifo_data,
  input  logic                  fifo_decode,
  output logic                  read_signal,
  output logic [Nbits_data-1:0] out_data,
  output logic                  out_corr,
  output logic                  out_uncorr,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      cnt_corr,
  output logic [CNT_W-1:0]      cnt_uncorr,
  output logic                  overflow
);

  localparam int AW = $clog2(OBUF_DEPTH);
  localparam int OW = AW + 1;
  localparam int SW = $clog2(Nbits_ham + 1);
  localparam int EW = Nbits_data + 2;

  logic [SW-1:0]         w_syn;
  logic [Nbits_ham-1:0]  w_fix;
  logic [Nbits_data-1:0] w_dat;
  logic                  w_corr;
  logic                  w_uncorr;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_full;
  logic [OW:0]           w_need;

  logic [EW-1:0]    r_mem [OBUF_DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [OW-1:0]    r_occ;
  logic [CNT_W-1:0] r_cnt_corr;
  logic [CNT_W-1:0] r_cnt_uncorr;
  logic             r_ovf;

  // Syndrome is the XOR of the positions of all set bits
  always_comb begin
    w_syn = '0;
    for (int p = 1; p <= Nbits_ham; p++) begin
      if (fifo_data[p-1]) w_syn = w_syn ^ SW'(p);
    end
  end

  assign w_corr   = (w_syn != '0) && (w_syn <= SW'(Nbits_ham));
  assign w_uncorr = w_syn > SW'(Nbits_ham);

  always_comb begin
    w_fix = fifo_data;
    for (int p = 1; p <= Nbits_ham; p++) begin
      if (w_corr && (w_syn == SW'(p))) w_fix[p-1] = ~fifo_data[p-1];
    end
  end

  // Data bits occupy the non-power-of-two positions in ascending order
  always_comb begin
    int j;
    j = 0;
    w_dat = '0;
    for (int p = 1; p <= Nbits_ham; p++) begin
      if ((p & (p - 1)) != 0) begin
        w_dat[j] = w_fix[p-1];
        j = j + 1;
      end
    end
  end

  assign out_valid = r_occ != '0;
  assign w_full    = r_occ == OW'(OBUF_DEPTH);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = fifo_decode & (~w_full | w_pop);

  // A word already in flight reserves its slot; a same-cycle pop is not credited
  assign w_need      = {1'b0, r_occ} + (OW+1)'(fifo_decode);
  assign read_signal = ~fifo_empty & ~rst &
                       (w_need < (OW+1)'(OBUF_DEPTH));

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {w_uncorr, w_corr, w_dat};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      unique case (1'b1)
        w_push & ~w_pop: r_occ <= r_occ + 1'b1;
        w_pop & ~w_push: r_occ <= r_occ - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_cnt_corr   <= '0;
      r_cnt_uncorr <= '0;
      r_ovf        <= 1'b0;
    end else begin
      if (fifo_decode & w_full & ~w_pop) r_ovf <= 1'b1;
      if (clr_cnt) begin
        r_cnt_corr   <= '0;
        r_cnt_uncorr <= '0;
      end else if (fifo_decode) begin
        if (w_corr && (r_cnt_corr != '1))
          r_cnt_corr <= r_cnt_corr + 1'b1;
        if (w_uncorr && (r_cnt_uncorr != '1))
          r_cnt_uncorr <= r_cnt_uncorr + 1'b1;
      end
    end
  end

  assign out_data   = r_mem[r_rd][Nbits_data-1:0];
  assign out_corr   = r_mem[r_rd][Nbits_data];
  assign out_uncorr = r_mem[r_rd][Nbits_data+1];
  assign cnt_corr   = r_cnt_corr;
  assign cnt_uncorr = r_cnt_uncorr;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_ldtu_hamm_ofifo_reader.sv
// Bench for ldtu_hamm_ofifo_reader: FIFO model, queue scoreboard,
// vector table and hand-written corner sequences.
module tb_ldtu_hamm_ofifo_reader;

  logic        CLK = 0;
  logic        rst;
  logic        fifo_empty;
  logic [37:0] fifo_data;
  logic        fifo_decode;
  logic        read_signal;
  logic [31:0] out_data;
  logic        out_corr;
  logic        out_uncorr;
  logic        out_valid;
  logic        out_ready;
  logic        clr_cnt;
  logic [7:0]  cnt_corr;
  logic [7:0]  cnt_uncorr;
  logic        overflow;

  ldtu_hamm_ofifo_reader dut (
    .CLK(CLK), .rst(rst), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_decode(fifo_decode),
    .read_signal(read_signal), .out_data(out_data),
    .out_corr(out_corr), .out_uncorr(out_uncorr),
    .out_valid(out_valid), .out_ready(out_ready),
    .clr_cnt(clr_cnt), .cnt_corr(cnt_corr),
    .cnt_uncorr(cnt_uncorr), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] d;
    logic        c;
    logic        u;
  } word_t;

  typedef struct {
    logic [37:0] cw;
    logic [31:0] d;
    logic        c;
    logic        u;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rd_cyc = 0;
  int pop_cyc = 0;
  int pop_cnt = 0;
  logic [37:0] q[$];
  word_t m_q[$];
  word_t last_pop;
  int m_cc = 0;
  int m_cu = 0;
  bit m_ovf = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [37:0] encode(logic [31:0] d);
    logic [37:0] cw;
    int j;
    bit par;
    cw = '0;
    j = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[j];
        j++;
      end
    for (int k = 0; k < 6; k++) begin
      par = 0;
      for (int p = 1; p <= 38; p++)
        if (((p >> k) & 1) == 1) par ^= cw[p-1];
      cw[(1 << k) - 1] = par;
    end
    return cw;
  endfunction

  function automatic word_t ref_decode(logic [37:0] cw_in);
    word_t w;
    logic [37:0] cw;
    int s;
    int j;
    cw = cw_in;
    s = 0;
    for (int p = 1; p <= 38; p++) if (cw[p-1]) s ^= p;
    w.c = (s >= 1 && s <= 38);
    w.u = (s >= 39);
    if (w.c) cw[s-1] = ~cw[s-1];
    w.d = '0;
    j = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin
        w.d[j] = cw[p-1];
        j++;
      end
    return w;
  endfunction

  function automatic logic [37:0] rand_cw(int nerr);
    logic [37:0] cw;
    int a;
    int b;
    cw = encode($urandom);
    a = $urandom_range(0, 37);
    b = (a + $urandom_range(1, 37)) % 38;
    if (nerr >= 1) cw[a] = ~cw[a];
    if (nerr >= 2) cw[b] = ~cw[b];
    return cw;
  endfunction

  task automatic push(logic [37:0] cw);
    q.push_back(cw);
    fifo_empty = 0;
  endtask

  task automatic step();
    bit rd;
    bit pop;
    bit full;
    word_t w;
    @(negedge CLK);
    cyc++;
    chk("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("out_data", out_data, m_q[0].d);
      chk("out_corr", out_corr, m_q[0].c);
      chk("out_uncorr", out_uncorr, m_q[0].u);
    end
    chk("cnt_corr", cnt_corr, m_cc);
    chk("cnt_uncorr", cnt_uncorr, m_cu);
    chk("overflow", overflow, m_ovf);
    chk("read_signal", read_signal,
        q.size() != 0 && (m_q.size() + int'(fifo_decode)) < 4);
    rd = read_signal && q.size() != 0;
    pop = out_ready && m_q.size() != 0;
    if (rd) rd_cyc = cyc;
    @(posedge CLK);
    full = m_q.size() == 4;
    if (fifo_decode) w = ref_decode(fifo_data);
    if (pop) begin
      last_pop = m_q.pop_front();
      pop_cnt++;
      pop_cyc = cyc;
    end
    if (fifo_decode) begin
      if (!full || pop) m_q.push_back(w);
      else m_ovf = 1;
    end
    if (clr_cnt) begin
      m_cc = 0;
      m_cu = 0;
    end else if (fifo_decode) begin
      if (w.c && m_cc != 255) m_cc++;
      if (w.u && m_cu != 255) m_cu++;
    end
    #1;
    if (rd) begin
      fifo_decode = 1;
      fifo_data = q.pop_front();
    end else begin
      fifo_decode = 0;
    end
    fifo_empty = q.size() == 0;
  endtask

  task automatic drain(int budget);
    int k;
    k = 0;
    while ((m_q.size() != 0 || q.size() != 0 || fifo_decode) && k < budget) begin
      step();
      k++;
    end
    chk("drain_timeout", k < budget, 1);
  endtask

  initial begin
    vec_t tv[5];
    int p0;
    int k;
    int first;
    logic [31:0] bp_d[8];

    tv[0] = '{38'h0, 32'h0, 1'b0, 1'b0};
    tv[1] = '{38'h7, 32'h1, 1'b0, 1'b0};
    tv[2] = '{38'h27, 32'h1, 1'b1, 1'b0};
    tv[3] = '{38'h5, 32'h1, 1'b1, 1'b0};
    tv[4] = '{38'h0080000040, 32'h8, 1'b0, 1'b1};

    rst = 1;
    fifo_empty = 1;
    fifo_data = '0;
    fifo_decode = 0;
    out_ready = 0;
    clr_cnt = 0;
    push(38'h7);
    push(38'h0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_read", read_signal, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_cc", cnt_corr, 0);
    chk("rst_cu", cnt_uncorr, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);
    q.delete();
    fifo_empty = 1;
    rst = 0;

    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      push(tv[i].cw);
      p0 = pop_cnt;
      k = 0;
      while (pop_cnt == p0 && k < 20) begin
        step();
        k++;
      end
      chk("tbl_arrive", pop_cnt, p0 + 1);
      chk("tbl_data", last_pop.d, tv[i].d);
      chk("tbl_corr", last_pop.c, tv[i].c);
      chk("tbl_uncorr", last_pop.u, tv[i].u);
      chk("tbl_latency", pop_cyc - rd_cyc, 2);
    end
    chk("tbl_cnt_corr", cnt_corr, 2);
    chk("tbl_cnt_uncorr", cnt_uncorr, 1);

    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      bp_d[i] = $urandom;
      push(encode(bp_d[i]));
    end
    repeat (12) step();
    chk("bp_fifo_left", q.size(), 4);
    chk("bp_valid", out_valid, 1);
    chk("bp_ovf", overflow, 0);
    out_ready = 1;
    p0 = pop_cnt;
    k = 0;
    while (pop_cnt < p0 + 8 && k < 40) begin
      step();
      k++;
    end
    chk("bp_count", pop_cnt - p0, 8);
    chk("bp_last", last_pop.d, bp_d[7]);

    for (int i = 0; i < 20; i++) push(rand_cw(0));
    p0 = pop_cnt;
    first = 0;
    k = 0;
    while (pop_cnt < p0 + 20 && k < 60) begin
      step();
      if (pop_cnt == p0 + 1 && first == 0) first = pop_cyc;
      k++;
    end
    chk("thru_count", pop_cnt - p0, 20);
    chk("thru_cycles", pop_cyc - first, 19);

    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      clr_cnt = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 6 && q.size() < 6)
        push(rand_cw($urandom_range(0, 2)));
      step();
    end
    clr_cnt = 0;
    out_ready = 1;
    drain(50);

    for (int i = 0; i < 300; i++) push(rand_cw(1));
    p0 = pop_cnt;
    k = 0;
    while (pop_cnt < p0 + 300 && k < 400) begin
      step();
      k++;
    end
    chk("sat_count", pop_cnt - p0, 300);
    chk("sat_cnt_corr", cnt_corr, 255);

    push(rand_cw(1));
    k = 0;
    while (!fifo_decode && k < 10) begin
      step();
      k++;
    end
    chk("clr_decode_seen", fifo_decode, 1);
    clr_cnt = 1;
    step();
    clr_cnt = 0;
    chk("clr_prio", cnt_corr, 0);
    drain(20);

    out_ready = 0;
    for (int i = 0; i < 4; i++) push(rand_cw(0));
    repeat (8) step();
    chk("ovf_full", out_valid, 1);
    chk("ovf_pre", overflow, 0);
    fifo_decode = 1;
    fifo_data = rand_cw(1);
    step();
    chk("ovf_set", overflow, 1);
    chk("ovf_cnt", cnt_corr, 1);
    out_ready = 1;
    drain(20);
    chk("ovf_sticky", overflow, 1);

    out_ready = 0;
    for (int i = 0; i < 5; i++) push(rand_cw(0));
    repeat (3) step();
    rst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_read", read_signal, 0);
    chk("mid_rst_ovf", overflow, 0);
    m_q.delete();
    m_cc = 0;
    m_cu = 0;
    m_ovf = 0;
    @(posedge CLK);
    #1;
    rst = 0;
    out_ready = 1;
    drain(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
